// File: rtl/rv_norm_pipe_pkg.sv
// Shared FPU package: default single-precision widths, exponent floor and
// the tag width shared with the rounding stage, plus a saturating counter helper.
package RV_fpu_pkg;

  localparam int MANW_SP   = 24;
  localparam int EXPW_SP   = 8;
  localparam int TAGW_SP   = 4;
  localparam int EXP_FLOOR = 0;

  // Increment a 32-bit event counter, sticking at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/RV_lzc.sv
// Leading/trailing zero counter. MODE=1 counts leading zeros from the MSB,
// MODE=0 counts trailing zeros from the LSB. valid_o=0 means the input is all zeros.
module RV_lzc #(
  parameter int N    = 24,
  parameter int MODE = 1,
  parameter int CW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  in_i,
  output logic [CW-1:0] cnt_o,
  output logic          valid_o
);

  logic found;

  // Scan from the chosen end and report the position of the first set bit.
  always_comb begin
    cnt_o = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && in_i[(MODE == 1) ? (N - 1 - i) : i]) begin
        cnt_o = CW'(i);
        found = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/rv_norm_pipe_pipe_reg.sv
// Valid/data pipeline register with load enable and synchronous active-low reset.
module rv_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         valid_in,
  input  logic [W-1:0] data_in,
  output logic         valid,
  output logic [W-1:0] data
);

  // Load valid and data together whenever the stage is allowed to advance.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (en) begin
      valid <= valid_in;
      data  <= data_in;
    end
  end

endmodule

// File: rtl/rv_norm_pipe.sv
// Two-stage elastic mantissa normalizer: S1 captures the raw operand, the
// S1->S2 path counts leading zeros and shifts, S2 holds the result.
// Optional macro RV_NORM_PERF_EN adds saturating zero/denorm transfer counters.
module rv_norm_pipe
  import RV_fpu_pkg::*;
#(
  parameter int MANW = MANW_SP,
  parameter int EXPW = EXPW_SP,
  parameter int TAGW = TAGW_SP
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [MANW-1:0] mant_i,
  input  logic [EXPW-1:0] exp_i,
  input  logic [TAGW-1:0] tag_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [MANW-1:0] mant_o,
  output logic [EXPW-1:0] exp_o,
  output logic [TAGW-1:0] tag_o,
  output logic            zero_o,
  output logic            denorm_o
`ifdef RV_NORM_PERF_EN
  ,
  output logic [31:0]     perf_zero_o,
  output logic [31:0]     perf_denorm_o
`endif
);

  localparam int LZW = (MANW > 1) ? $clog2(MANW) : 1;
  localparam int CW  = (LZW > EXPW) ? LZW : EXPW;
  localparam int S1W = MANW + EXPW + TAGW;
  localparam int S2W = S1W + 2;

  logic            v1, v2, adv1, adv2;
  logic [S1W-1:0]  s1_q;
  logic [S2W-1:0]  s2_q;
  logic [MANW-1:0] s1_mant;
  logic [EXPW-1:0] s1_exp;
  logic [TAGW-1:0] s1_tag;
  logic [LZW-1:0]  lz;
  logic            nz;
  logic [CW-1:0]   lz_w, exp_w;
  logic [MANW-1:0] n_mant;
  logic [EXPW-1:0] n_exp;
  logic            n_zero, n_den;

  assign adv2    = !v2 | ready_i;
  assign adv1    = !v1 | adv2;
  assign ready_o = adv1;

  rv_pipe_reg #(.W(S1W)) u_s1 (
    .clk      (clk),
    .reset    (reset),
    .en       (adv1),
    .valid_in (valid_i),
    .data_in  ({mant_i, exp_i, tag_i}),
    .valid    (v1),
    .data     (s1_q)
  );

  assign {s1_mant, s1_exp, s1_tag} = s1_q;

  RV_lzc #(.N(MANW), .MODE(1), .CW(LZW)) u_lzc (
    .in_i    (s1_mant),
    .cnt_o   (lz),
    .valid_o (nz)
  );

  // Shift out leading zeros, but never drive the exponent below the floor;
  // when the exponent runs out first the result is left denormal.
  always_comb begin
    lz_w             = '0;
    lz_w[LZW-1:0]    = lz;
    exp_w            = '0;
    exp_w[EXPW-1:0]  = s1_exp;
    n_mant           = '0;
    n_exp            = EXPW'(EXP_FLOOR);
    n_zero           = 1'b0;
    n_den            = 1'b0;
    if (!nz) begin
      n_zero = 1'b1;
    end else if (lz_w < exp_w) begin
      n_mant = s1_mant << lz_w;
      n_exp  = s1_exp - lz_w[EXPW-1:0];
    end else begin
      n_mant = s1_mant << exp_w;
      n_den  = 1'b1;
    end
  end

  rv_pipe_reg #(.W(S2W)) u_s2 (
    .clk      (clk),
    .reset    (reset),
    .en       (adv2),
    .valid_in (v1),
    .data_in  ({n_mant, n_exp, s1_tag, n_zero, n_den}),
    .valid    (v2),
    .data     (s2_q)
  );

  assign valid_o = v2;
  assign {mant_o, exp_o, tag_o, zero_o, denorm_o} = s2_q;

`ifdef RV_NORM_PERF_EN
  // Count zero and denormal results as they leave the block.
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_zero_o   <= '0;
      perf_denorm_o <= '0;
    end else if (valid_o && ready_i) begin
      if (zero_o)   perf_zero_o   <= sat_inc32(perf_zero_o);
      if (denorm_o) perf_denorm_o <= sat_inc32(perf_denorm_o);
    end
  end
`endif

endmodule

// File: doc/rv_norm_pipe.md
Name: rv_norm_pipe

Overview:
- Two-stage elastic normalization pipeline used in the GPGPU FPU datapath: int-to-float conversion, post-add cancellation and FMA result normalization.
- Accepts an unnormalized mantissa with its biased exponent and counts leading zeros with RV_lzc (MODE=1).
- Left-shifts the mantissa so its MSB is 1 and decrements the exponent by the same amount, clamping at exponent 0 so results denormalize.
- Sits upstream of the rounding stage; uses valid/ready handshakes on both sides.

Parameters:
- MANW, 24, mantissa width in bits including the hidden bit.
- EXPW, 8, biased exponent width.
- TAGW, 4, width of the opaque tag (warp/lane/op id) carried alongside the data.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
- valid_i  in  1  input beat valid
- ready_o  out  1  block can accept an input beat
- mant_i  in  MANW  unnormalized mantissa
- exp_i  in  EXPW  biased exponent
- tag_i  in  TAGW  sideband tag
- valid_o  out  1  output beat valid
- ready_i  in  1  downstream accepts the output beat
- mant_o  out  MANW  normalized mantissa
- exp_o  out  EXPW  adjusted exponent
- tag_o  out  TAGW  tag, passed unchanged
- zero_o  out  1  mant_i was all zeros
- denorm_o  out  1  shift was clamped by the exponent

Behaviour:
- Stage S1 register holds mant, exp, tag and v1. Stage S2 register holds the outputs and v2, which drives valid_o.
- Handshakes:
  - adv2 = !v2 | ready_i.
  - adv1 = !v1 | adv2.
  - ready_o = adv1.
  - An input transfer occurs when valid_i & ready_o. An output transfer occurs when valid_o & ready_i.
- Latency: 2 cycles from an accepted input to valid_o with no stall. Throughput is 1 beat/cycle when ready_i is held high.
- Stall: when ready_i=0 and v2=1, S2 holds. S1 holds if v1=1. ready_o then falls combinationally within the same cycle. No beat is lost or duplicated.
- S1->S2 combinational path:
  - lz = leading-zero count of the S1 mantissa, from RV_lzc with N=MANW. lzc valid_o=0 means zero.
  - If zero: mant_o=0, exp_o=0, zero_o=1, denorm_o=0.
  - Else if lz < exp: shift by lz, exp_o = exp - lz, denorm_o=0.
  - Else (lz >= exp): shift by exp, exp_o=0, denorm_o=1. For exp=0 the mantissa passes unshifted with denorm_o=1.
  - The subtraction is EXPW wide. lz is zero-extended to EXPW when MANW fits, otherwise compared at max width. exp_o never wraps below 0.
- Output data registers update only on adv2. While valid_o=1 and ready_i=0, the outputs are stable.
- Reset: v1=v2=0. All data registers clear to 0, so mant_o=0, exp_o=0, tag_o=0, zero_o=0, denorm_o=0, valid_o=0. ready_o=1 the cycle after reset deasserts.
- Reset mid-operation flushes both stages and drops in-flight beats without producing an output.
- Simultaneous input accept and output drain in the same cycle when full: both stages advance.

Optional Feature:
- Macro: RV_NORM_PERF_EN.
- With the macro defined:
  - Adds outputs perf_zero_o [31:0] and perf_denorm_o [31:0].
  - Each counts output transfers with zero_o=1 or denorm_o=1 respectively.
  - Counters saturate at 32'hFFFFFFFF and reset to 0.
- Without the macro: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package RV_fpu_pkg holds:
  - the default widths (MANW_SP=24, EXPW_SP=8);
  - a constant for the exponent floor (0);
  - the tag width constant shared with the rounding stage.
- Sub-module: the existing RV_lzc is instantiated inside.
- One natural new sub-module, rv_pipe_reg: a valid/ready pipeline register with enable and synchronous active-low reset. It is instantiated twice.

Test Plan:
- mant_i=24'h000F00, exp_i=100 -> after 2 cycles mant_o=24'hF00000, exp_o=88, zero_o=0, denorm_o=0.
- mant_i=24'h000001, exp_i=5 -> mant_o=24'h000020, exp_o=0, denorm_o=1.
- mant_i=0, exp_i=77, tag_i=4'hA -> mant_o=0, exp_o=0, zero_o=1, tag_o=4'hA.
- Back-to-back stream of 8 beats with ready_i=0 for cycles 3-6 -> ready_o=0 while both stages are full; all 8 beats emerge in order, none dropped or duplicated.
- reset=0 asserted with 2 beats in flight -> valid_o=0 next cycle; all outputs 0; the flushed beats never appear.
- With RV_NORM_PERF_EN defined: 3 zero and 2 denorm beats transferred -> perf_zero_o=3, perf_denorm_o=2.
